// File: rtl/usermem_arbiter.sv
// usermem_arbiter: shares one user memory between the CU port and the HOST
// port. Each access runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE, and
// simultaneous requests alternate round-robin. All outputs are registered.
module usermem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cu_req,
    input  logic              cu_rw,
    input  logic [ADDR_W-1:0] cu_addr,
    input  logic [DATA_W-1:0] cu_wdata,
    output logic [DATA_W-1:0] cu_rdata,
    output logic              cu_ack,
    input  logic              host_req,
    input  logic              host_rw,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    // Wait counter is 3 bits wide: WAIT_STATES is limited to 0..7.
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_last_owner;
    logic              r_owner;
    logic              r_mem_en;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_cu_rdata;
    logic [DATA_W-1:0] r_host_rdata;
    logic              r_cu_ack;
    logic              r_host_ack;
    logic              r_busy;

    logic              w_any_req;
    logic              w_grant_host;
    logic              w_sel_rw;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // On a tie the port that did not win last time is granted; otherwise the lone requester.
    assign w_any_req    = cu_req | host_req;
    assign w_grant_host = (cu_req & host_req) ? ~r_last_owner : host_req;
    assign w_sel_rw     = w_grant_host ? host_rw    : cu_rw;
    assign w_sel_addr   = w_grant_host ? host_addr  : cu_addr;
    assign w_sel_wdata  = w_grant_host ? host_wdata : cu_wdata;

    // Arbitration FSM with registered memory-side and port-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_last_owner  <= 1'b1;
            r_owner       <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_rw      <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_cu_rdata    <= '0;
            r_host_rdata  <= '0;
            r_cu_ack      <= 1'b0;
            r_host_ack    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cu_ack   <= 1'b0;
                    r_host_ack <= 1'b0;
                    if (w_any_req) begin
                        r_mem_rw      <= w_sel_rw;
                        r_mem_address <= w_sel_addr;
                        r_mem_wdata   <= w_sel_wdata;
                        r_owner       <= w_grant_host;
                        r_last_owner  <= w_grant_host;
                        r_cnt         <= WAIT_INIT;
                        r_mem_en      <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 3'd0) begin
                        // Read data is only valid in the last access cycle.
                        if (!r_mem_rw) begin
                            if (r_owner) r_host_rdata <= mem_rdata;
                            else         r_cu_rdata   <= mem_rdata;
                        end
                        r_mem_en   <= 1'b0;
                        r_cu_ack   <= ~r_owner;
                        r_host_ack <= r_owner;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    r_cu_ack   <= 1'b0;
                    r_host_ack <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_mem_en   <= 1'b0;
                    r_cu_ack   <= 1'b0;
                    r_host_ack <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign cu_rdata    = r_cu_rdata;
    assign cu_ack      = r_cu_ack;
    assign host_rdata  = r_host_rdata;
    assign host_ack    = r_host_ack;
    assign mem_en      = r_mem_en;
    assign mem_rw      = r_mem_rw;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = r_busy;
    assign owner       = r_owner;

endmodule

// File: tb/tb_usermem_arbiter.sv
// Testbench for usermem_arbiter: transaction-timing reference model,
// directed scenarios and randomized two-port traffic.
module tb_usermem_arbiter;

    localparam int W = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Main instance (WAIT_STATES = 1)
    logic       cu_req = 0, cu_rw = 0, host_req = 0, host_rw = 0;
    logic [7:0] cu_addr = 0, cu_wdata = 0, host_addr = 0, host_wdata = 0;
    logic [7:0] cu_rdata, host_rdata, mem_address, mem_wdata;
    logic [7:0] mem_rdata = 0;
    logic       cu_ack, host_ack, mem_en, mem_rw, busy, owner;

    // Second instance (WAIT_STATES = 3), CU port only
    logic       cu_req3 = 0, cu_rw3 = 0;
    logic [7:0] cu_addr3 = 0, cu_wdata3 = 0, mem_rdata3 = 0;
    logic [7:0] cu_rdata3, host_rdata3, mem_address3, mem_wdata3;
    logic       cu_ack3, host_ack3, mem_en3, mem_rw3, busy3, owner3;

    usermem_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(W)) u_dut (
        .clk(clk), .reset(rst_n),
        .cu_req(cu_req), .cu_rw(cu_rw), .cu_addr(cu_addr), .cu_wdata(cu_wdata),
        .cu_rdata(cu_rdata), .cu_ack(cu_ack),
        .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    usermem_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(rst_n),
        .cu_req(cu_req3), .cu_rw(cu_rw3), .cu_addr(cu_addr3), .cu_wdata(cu_wdata3),
        .cu_rdata(cu_rdata3), .cu_ack(cu_ack3),
        .host_req(1'b0), .host_rw(1'b0), .host_addr(8'h00), .host_wdata(8'h00),
        .host_rdata(host_rdata3), .host_ack(host_ack3),
        .mem_en(mem_en3), .mem_rw(mem_rw3), .mem_address(mem_address3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory seen by the DUT, and the model's own copy of the same contents.
    logic [7:0] tmem [256];
    logic [7:0] mmem [256];

    always @(posedge clk) if (mem_en && mem_rw) tmem[mem_address] <= mem_wdata;

    // Reference model: a transaction granted in cycle g occupies cycles g+1..g+W+1
    // on the memory, acks in g+W+2, and the arbiter is free again from g+W+3.
    int         m_cyc = 0, m_gs = 0, m_t = 0;
    bit         m_act = 0, m_last = 1, m_owner = 0;
    logic       m_rw = 0;
    logic [7:0] m_addr = 0, m_wd = 0;
    logic       e_en = 0, e_busy = 0, e_cuack = 0, e_hack = 0, e_lastacc = 0;
    logic [7:0] e_curd = 0, e_hrd = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_act = 0; m_last = 1; m_owner = 0; m_rw = 0; m_addr = 0; m_wd = 0;
            e_en = 0; e_busy = 0; e_cuack = 0; e_hack = 0; e_lastacc = 0;
            e_curd = 0; e_hrd = 0; m_cyc = 0; m_gs = 0;
        end else begin
            if ((!m_act || (m_cyc - m_gs) >= W + 3) && (cu_req || host_req)) begin
                m_owner = (cu_req && host_req) ? !m_last : host_req;
                m_last  = m_owner;
                m_act   = 1;
                m_gs    = m_cyc;
                if (m_owner) begin m_rw = host_rw; m_addr = host_addr; m_wd = host_wdata; end
                else         begin m_rw = cu_rw;   m_addr = cu_addr;   m_wd = cu_wdata;   end
            end
            m_t       = m_cyc + 1 - m_gs;
            e_en      = m_act && m_t >= 1 && m_t <= W + 1;
            e_busy    = m_act && m_t >= 1 && m_t <= W + 2;
            e_lastacc = m_act && m_t == W + 1;
            e_cuack   = m_act && m_t == W + 2 && !m_owner;
            e_hack    = m_act && m_t == W + 2 && m_owner;
            if (m_act && m_t == W + 2) begin
                if (m_rw)         mmem[m_addr] = m_wd;
                else if (m_owner) e_hrd = mmem[m_addr];
                else              e_curd = mmem[m_addr];
            end
            m_cyc++;
        end
    end

    // Read data is garbage except in the last access cycle.
    always @(negedge clk)
        mem_rdata <= e_lastacc ? tmem[mem_address] : ~tmem[mem_address];

    // Compare every output against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("flags", {busy, mem_en, cu_ack, host_ack}, {e_busy, e_en, e_cuack, e_hack});
            check("owner", owner, m_owner);
            check("mem_rw", mem_rw, m_rw);
            check("mem_addr", mem_address, m_addr);
            check("mem_wdata", mem_wdata, m_wd);
            check("cu_rdata", cu_rdata, e_curd);
            check("host_rdata", host_rdata, e_hrd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input bit hp, input int bound, output int n);
        n = 0;
        do begin tick(); n++; end while (!(hp ? host_ack : cu_ack) && n < bound);
        check("ack_seen", hp ? host_ack : cu_ack, 1);
    endtask

    task automatic new_cu();
        cu_req = 1; cu_rw = 1'($urandom % 2);
        cu_addr = 8'($urandom_range(15, 0)); cu_wdata = 8'($urandom);
    endtask

    task automatic new_host();
        host_req = 1; host_rw = 1'($urandom % 2);
        host_addr = 8'($urandom_range(15, 0)); host_wdata = 8'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, cu_t, h_t, nack, idle, cnt;
        logic [7:0] hrd0, v;
        int ord[$];

        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom); tmem[i] = v; mmem[i] = v;
        end
        #1 rst_n = 0; chk_en = 1;
        tick(); tick();
        rst_n = 1;
        tick();
        check("rst_flags", {busy, mem_en, cu_ack, host_ack, owner, mem_rw}, 0);
        check("rst_rdata", {cu_rdata, host_rdata}, 0);
        check("rst_mem", {mem_address, mem_wdata}, 0);

        // Single CU read of 0x3C
        tmem[8'h3C] = 8'hA5; mmem[8'h3C] = 8'hA5;
        cu_rw = 0; cu_addr = 8'h3C; cu_req = 1;
        tick();
        check("t1_c1_en_rw", {mem_en, mem_rw}, 2'b10);
        check("t1_c1_addr", mem_address, 8'h3C);
        tick();
        check("t1_c2_en_ack", {mem_en, cu_ack}, 2'b10);
        tick();
        check("t1_c3_ack", {cu_ack, host_ack, mem_en}, 3'b100);
        check("t1_c3_rdata", cu_rdata, 8'hA5);
        cu_req = 0;
        tick();
        check("t1_c4_idle", {cu_ack, busy}, 0);

        // HOST write 0x5A to 0x10, then CU read 0x10
        hrd0 = host_rdata;
        host_rw = 1; host_addr = 8'h10; host_wdata = 8'h5A; host_req = 1;
        wait_ack(1, 10, n);
        check("t2_host_lat", n, 3);
        host_req = 0;
        tick();
        cu_rw = 0; cu_addr = 8'h10; cu_req = 1;
        wait_ack(0, 10, n);
        check("t2_cu_rdata", cu_rdata, 8'h5A);
        check("t2_host_rdata", host_rdata, hrd0);
        cu_req = 0;
        tick();

        // Tie straight out of reset
        rst_n = 0;
        tick();
        rst_n = 1;
        cu_rw = 0; cu_addr = 8'h01; cu_req = 1;
        host_rw = 0; host_addr = 8'h02; host_req = 1;
        cu_t = -1; h_t = -1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) check("t3_owner", owner, 0);
            if (cu_ack)   begin cu_t = c; cu_req = 0; end
            if (host_ack) begin h_t = c; host_req = 0; end
        end
        check("t3_cu_ack_cyc", cu_t, 3);
        check("t3_host_gap", h_t - cu_t, 4);

        // Sustained contention: both requests held for six transactions
        cu_rw = 0; cu_addr = 8'h05; cu_req = 1;
        host_rw = 0; host_addr = 8'h06; host_req = 1;
        nack = 0; idle = 0;
        for (int c = 0; c < 80 && nack < 6; c++) begin
            tick();
            if (cu_ack) begin ord.push_back(0); nack++; end
            else if (host_ack) begin ord.push_back(1); nack++; end
            else if (!busy && nack > 0) idle++;
        end
        cu_req = 0; host_req = 0;
        check("t4_nack", nack, 6);
        check("t4_idle", idle, 5);
        for (int i = 0; i < ord.size(); i++) check("t4_order", ord[i], i % 2);
        repeat (4) tick();

        // Reset during the first ACCESS cycle of a CU write
        cu_rw = 1; cu_addr = 8'h20; cu_wdata = 8'hEE; cu_req = 1;
        tick();
        check("t5_access", mem_en, 1);
        #1 rst_n = 0; cu_req = 0;
        #1 check("t5_async", {mem_en, busy, cu_ack}, 0);
        tick(); tick();
        rst_n = 1;
        check("t5_out", {busy, mem_en, cu_ack, host_ack, owner, mem_rw}, 0);
        check("t5_mem", {mem_address, mem_wdata}, 0);
        check("t5_rdata", {cu_rdata, host_rdata}, 0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin tick(); if (cu_ack) cnt++; end
        check("t5_no_ack", cnt, 0);

        // WAIT_STATES=3 instance: CU read with req dropped in cycle 2
        cu_rw3 = 0; cu_addr3 = 8'h44; cu_req3 = 1; mem_rdata3 = 8'h00;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) check("t6_en", {mem_en3, cu_ack3}, 2'b10);
            if (c == 1) check("t6_addr", mem_address3, 8'h44);
            if (c == 2) cu_req3 = 0;
            if (c == 4) mem_rdata3 = 8'hC3;
            if (c == 5) begin
                check("t6_ack", {cu_ack3, mem_en3, host_ack3}, 3'b100);
                check("t6_rdata", cu_rdata3, 8'hC3);
                mem_rdata3 = 8'h00;
            end
            if (c == 6) check("t6_idle", {cu_ack3, busy3}, 0);
        end

        // Randomized traffic on the main instance
        for (int c = 0; c < 600; c++) begin
            tick();
            if (cu_req && cu_ack) begin
                if ($urandom % 3 == 0) new_cu(); else cu_req = 0;
            end else if (!cu_req && $urandom % 4 == 0) new_cu();
            if (host_req && host_ack) begin
                if ($urandom % 3 == 0) new_host(); else host_req = 0;
            end else if (!host_req && $urandom % 4 == 0) new_host();
        end
        cu_req = 0; host_req = 0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/usermem_arbiter.md
# usermem_arbiter

Two-port arbiter that shares the single 8-bit user memory between the control unit (CU port) and an external host/loader (HOST port). It sits between the processor enclosure and the user memory array, and replaces the direct CU-to-memory connection with a request/acknowledge handshake on each side. It sequences each access through a fixed-latency memory cycle and returns read data. Simultaneous requests are resolved round-robin.

## Interface

**Parameters**
- ADDR_W, 8, address width of user memory
- DATA_W, 8, data width of user memory
- WAIT_STATES, 1, extra memory cycles per access (0..7); ACCESS lasts WAIT_STATES+1 cycles

**Ports**
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cu_req  in  1  CU access request, held until cu_ack
- cu_rw  in  1  1 = write, 0 = read
- cu_addr  in  ADDR_W  CU address
- cu_wdata  in  DATA_W  CU write data
- cu_rdata  out  DATA_W  last read data returned to CU
- cu_ack  out  1  one-cycle completion pulse to CU
- host_req, host_rw, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  same meaning for HOST port
- host_rdata  out  DATA_W  last read data returned to HOST
- host_ack  out  1  one-cycle completion pulse to HOST
- mem_en  out  1  memory cycle active
- mem_rw  out  1  1 = write, 0 = read
- mem_address  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in last ACCESS cycle
- busy  out  1  high whenever state is not IDLE
- owner  out  1  port of current/last grant: 0 = CU, 1 = HOST

## Operation

- FSM states: IDLE, ACCESS, DONE.
- IDLE: if exactly one req is high, grant it. If both are high, grant the port that is not `last_owner`. If neither is high, stay in IDLE.
- On grant, latch the winner's rw, addr, and wdata into the mem_* registers. Set owner and last_owner. Load wait counter with WAIT_STATES. Go to ACCESS.
- ACCESS: mem_en=1 and the mem_* outputs are stable. The counter decrements each cycle.
  - When the counter is 0: for a read, capture mem_rdata into the owner's rdata register; then go to DONE.
  - Writes leave both rdata registers unchanged.
- DONE: pulse the owner's ack for exactly one cycle with mem_en=0, then go to IDLE.
- Requests are sampled only in IDLE; the arbiter never preempts an access in progress.
- The requester drops req on the edge where it sees ack=1. If req is still high in the following IDLE cycle, it is a new back-to-back transaction.
- Owner drops req during ACCESS (protocol violation): the access still completes and the ack still pulses. No abort path exists.
- The non-owner may assert or drop its req at any time; only its level in IDLE matters.
- rdata registers hold their value until the next read completes for that port.
- Reset values:
  - state = IDLE; mem_en = 0; mem_rw = 0; mem_address = 0; mem_wdata = 0
  - cu_rdata = 0; host_rdata = 0; cu_ack = 0; host_ack = 0; busy = 0
  - owner = 0; last_owner = 1, so the CU wins the first tie.

## Timing

- Cycle 0: req is high in IDLE. Cycles 1..WAIT_STATES+1: ACCESS. Cycle WAIT_STATES+2: DONE with ack high.
- With WAIT_STATES=1, ack arrives 3 cycles after the request is sampled. Read data is valid on rdata in the same cycle as ack.
- Minimum spacing between grants is WAIT_STATES+3 cycles (IDLE, ACCESS, DONE).
- Under continuous dual requests, grants strictly alternate CU, HOST, CU, and so on. Neither port waits more than one transaction.
- All outputs are registered. mem_en and ack are Moore decodes of registered state.
- Asserting reset mid-ACCESS clears mem_en and any pending ack immediately (asynchronous). The in-flight access is lost, and no ack is ever issued for it.

## Test plan

- **Single CU read:** WAIT_STATES=1, memory word 0x3C holds 0xA5, CU reads 0x3C. Required: mem_en high for cycles 1-2 with mem_address=0x3C and mem_rw=0; cu_ack pulses at cycle 3 with cu_rdata=0xA5; host_ack stays 0.
- **HOST write then CU read:** HOST writes 0x5A to address 0x10, then CU reads 0x10. Required: one host_ack, then one cu_ack with cu_rdata=0x5A; host_rdata unchanged.
- **Tie after reset:** both ports request on the same cycle straight out of reset. Required: CU is served first (owner=0); HOST is served next, with host_ack exactly 4 cycles after cu_ack.
- **Sustained contention:** both req held high for 6 transactions. Required: ack order is CU, HOST, CU, HOST, CU, HOST; busy stays high except for one IDLE cycle between transactions.
- **Reset mid-access:** assert reset during the first ACCESS cycle of a CU write. Required: mem_en=0 immediately; no cu_ack; after release, state is IDLE and all outputs are at reset values.
- **WAIT_STATES=3:** CU read. Required: mem_en high for 4 cycles; cu_ack at cycle 5; an owner req drop in cycle 2 still yields cu_ack.
